// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter/receiver state type and default bit timing
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int CLKS_PER_BIT_DEFAULT = 434;
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: byte FIFO (push/din in, pop/dout out, count/full/empty status); push while full is taken only with a same-cycle pop
module tx_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [7:0]                    din,
  output logic [7:0]                    dout,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic wr;
  assign full = count == CW'(FIFO_DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  assign wr = push && (!full || pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr) - CW'(pop);
    end
  end
endmodule

// File: rtl/tx_block.sv
// tx_block: buffered 8N1 UART transmitter (tx_data/tx_load in, cts gating, error_clear; serial_out, fifo_full, busy, overrun_error out)
module tx_block import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  input  logic       cts,
  input  logic       error_clear,
  output logic       serial_out,
  output logic       fifo_full,
  output logic       busy,
  output logic       overrun_error
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  tx_state_t state, state_n;
  logic [BW-1:0] baud;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, dout;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic empty, pop, baud_done, drop;
  tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(tx_load), .pop(pop), .din(tx_data),
    .dout(dout), .count(count), .full(fifo_full), .empty(empty)
  );
  assign baud_done = baud == BW'(CLKS_PER_BIT - 1);
  assign busy = state != IDLE || count != '0;
  assign drop = tx_load && fifo_full && !pop;
  always_comb begin
    pop = !empty && cts && (state == IDLE || (state == STOP && baud_done));
    state_n = state;
    case (state)
      IDLE:  state_n = pop ? START : IDLE;
      START: state_n = baud_done ? DATA : START;
      DATA:  state_n = (baud_done && idx == 3'd7) ? STOP : DATA;
      STOP:  state_n = baud_done ? (pop ? START : IDLE) : STOP;
      default: state_n = IDLE;
    endcase
    idx_n = state != DATA ? 3'd0 : baud_done ? idx + 3'd1 : idx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      idx <= '0;
      shift <= '0;
      serial_out <= 1'b1;
      overrun_error <= 1'b0;
    end else begin
      state <= state_n;
      baud <= (state_n == IDLE || state_n != state || baud_done) ? '0 : baud + 1'b1;
      idx <= idx_n;
      if (pop) shift <= dout;
      serial_out <= state_n == START ? 1'b0 : state_n == DATA ? shift[idx_n] : 1'b1;
      overrun_error <= drop ? 1'b1 : error_clear ? 1'b0 : overrun_error;
    end
  end
endmodule

// File: tb/tb_tx_block.sv
// tb_tx_block: directed self-checking bench for tx_block at 4 clocks per bit, 4-entry FIFO
module tb_tx_block;
  logic clk = 0, rst = 1, tx_load = 0, cts = 1, error_clear = 0;
  logic [7:0] tx_data = '0;
  logic serial_out, fifo_full, busy, overrun_error;
  int checks = 0, errors = 0;
  tx_block #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_load(tx_load), .cts(cts),
    .error_clear(error_clear), .serial_out(serial_out), .fifo_full(fifo_full),
    .busy(busy), .overrun_error(overrun_error)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, act, exp);
    end
  endtask
  task automatic load(input logic [7:0] b);
    tx_data = b;
    tx_load = 1;
    tick();
    tx_load = 0;
  endtask
  task automatic check_frame(input logic [7:0] b, input int drop_bit);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++)
      for (int c = 0; c < 4; c++) begin
        if (i == drop_bit && c == 0) cts = 0;
        chk($sformatf("frame_%h_bit%0d_cyc%0d", b, i, c), {7'd0, serial_out}, {7'd0, f[i]});
        tick();
      end
  endtask
  initial begin
    logic seen_low;
    tick(); tick();
    rst = 0;
    tick();
    chk("reset_serial", {7'd0, serial_out}, 8'd1);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_full", {7'd0, fifo_full}, 8'd0);
    chk("reset_overrun", {7'd0, overrun_error}, 8'd0);
    load(8'h41);
    chk("load_idle_serial", {7'd0, serial_out}, 8'd1);
    chk("load_busy", {7'd0, busy}, 8'd1);
    tick();
    check_frame(8'h41, -1);
    chk("after_41_busy", {7'd0, busy}, 8'd0);
    chk("after_41_serial", {7'd0, serial_out}, 8'd1);
    tx_data = 8'h55; tx_load = 1; tick();
    tx_data = 8'hA3; tick();
    tx_load = 0;
    check_frame(8'h55, -1);
    check_frame(8'hA3, -1);
    chk("after_pair_busy", {7'd0, busy}, 8'd0);
    cts = 0;
    load(8'h11); load(8'h22); load(8'h33);
    chk("three_not_full", {7'd0, fifo_full}, 8'd0);
    load(8'h44);
    chk("four_full", {7'd0, fifo_full}, 8'd1);
    chk("four_no_overrun", {7'd0, overrun_error}, 8'd0);
    load(8'h55);
    chk("five_overrun", {7'd0, overrun_error}, 8'd1);
    load(8'h66);
    chk("six_full", {7'd0, fifo_full}, 8'd1);
    chk("cts_low_serial", {7'd0, serial_out}, 8'd1);
    tick();
    chk("cts_low_serial2", {7'd0, serial_out}, 8'd1);
    cts = 1;
    tick();
    check_frame(8'h11, -1);
    check_frame(8'h22, -1);
    check_frame(8'h33, -1);
    check_frame(8'h44, -1);
    chk("after_four_busy", {7'd0, busy}, 8'd0);
    chk("overrun_sticky", {7'd0, overrun_error}, 8'd1);
    error_clear = 1; tick(); error_clear = 0;
    chk("overrun_cleared", {7'd0, overrun_error}, 8'd0);
    tx_data = 8'h96; tx_load = 1; tick();
    tx_data = 8'h3C; tick();
    tx_load = 0;
    check_frame(8'h96, 3);
    for (int i = 0; i < 8; i++) begin
      chk("cts_hold_serial", {7'd0, serial_out}, 8'd1);
      tick();
    end
    chk("cts_hold_busy", {7'd0, busy}, 8'd1);
    cts = 1;
    tick();
    check_frame(8'h3C, -1);
    tx_data = 8'h0F; tx_load = 1; tick();
    tx_data = 8'hF0; tick();
    tx_data = 8'h77; tick();
    tx_load = 0;
    for (int i = 0; i < 13; i++) tick();
    chk("pre_reset_busy", {7'd0, busy}, 8'd1);
    rst = 1; tick();
    chk("midframe_rst_serial", {7'd0, serial_out}, 8'd1);
    chk("midframe_rst_busy", {7'd0, busy}, 8'd0);
    rst = 0;
    seen_low = 0;
    for (int i = 0; i < 60; i++) begin
      if (serial_out !== 1'b1) seen_low = 1;
      tick();
    end
    chk("no_tx_after_rst", {7'd0, seen_low}, 8'd0);
    chk("idle_after_rst_busy", {7'd0, busy}, 8'd0);
    cts = 0;
    load(8'h01); load(8'h02); load(8'h03); load(8'h04);
    tx_data = 8'h05; tx_load = 1; error_clear = 1; tick();
    tx_load = 0;
    chk("set_wins_overrun", {7'd0, overrun_error}, 8'd1);
    error_clear = 0; tick();
    chk("overrun_still_set", {7'd0, overrun_error}, 8'd1);
    error_clear = 1; tick(); error_clear = 0;
    chk("clear_alone", {7'd0, overrun_error}, 8'd0);
    rst = 1; tx_load = 1; tx_data = 8'hEE; cts = 1; tick();
    rst = 0; tx_load = 0; tick();
    chk("load_in_rst_busy", {7'd0, busy}, 8'd0);
    chk("load_in_rst_full", {7'd0, fifo_full}, 8'd0);
    chk("load_in_rst_serial", {7'd0, serial_out}, 8'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
